reset_sequencer: RTL and testbench

Sequences a bank of single-domain reset generators: each generator has an active-high ASSERT input that drives its domain reset low, and this block drives those inputs. On a request it asserts the stages in order with a fixed gap, holds all of them, then releases them in reverse order, and pulses DONE. Up to NUM_REQ requesters share it under fixed-priority arbitration. It sits in the clock/reset infrastructure between reset sources (watchdog, software, debug) and the per-domain reset generators.

---
 rtl/reset_sequencer_pkg.sv | 24 ++
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer_arbiter.sv | 13 +
 rtl/reset_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and
// width helpers for the stage index and the shared down-counter.
package rstseq_defs;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ASSERTING = 3'd1,
        ST_HOLD      = 3'd2,
        ST_RELEASING = 3'd3,
        ST_FINISH    = 3'd4
    } rstseqState_t;

    function automatic int stageIdxWidth(input int numStages);
        return (numStages <= 1) ? 1 : $clog2(numStages);
    endfunction

    // Bits needed to hold the larger of the two timed intervals.
    function automatic int cntWidthFor(input int gapCycles, input int holdCycles);
        int maxVal;
        maxVal = (gapCycles > holdCycles) ? gapCycles : holdCycles;
        return (maxVal <= 1) ? 1 : $clog2(maxVal + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Request/grant and stage-assert bundle between reset sources, the
// sequencer (slave side) and the per-domain reset generators.
interface reset_sequencer_if #(
    parameter int NUM_REQ    = 2,
    parameter int NUM_STAGES = 3
);

    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ-1:0]    grant;
    logic                  busy;
    logic                  done;
    logic [NUM_STAGES-1:0] stageAssert;

    modport master (
        output req,
        input  grant,
        input  busy,
        input  done,
        input  stageAssert
    );

    modport slave (
        input  req,
        output grant,
        output busy,
        output done,
        output stageAssert
    );

endinterface

// File: rtl/reset_sequencer_arbiter.sv
// Combinational fixed-priority picker: returns the lowest set bit of the
// request vector as a one-hot grant (all zero when nothing is requested).
module rstseq_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    output logic [NUM_REQ-1:0] o_grant
);

    // Two's-complement trick isolates the least significant set bit.
    assign o_grant = i_req & (~i_req + NUM_REQ'(1));

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset sequencer: asserts stages upward with a fixed gap, holds,
// releases downward, pulses done. Optional macro RSTSEQ_PENDING_EN latches
// requests seen while busy (or lost in arbitration) so they are served later.
module reset_sequencer
    import rstseq_defs::*;
#(
    parameter int NUM_STAGES  = 3,
    parameter int NUM_REQ     = 2,
    parameter int GAP_CYCLES  = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    reset_sequencer_if.slave bus
);

    localparam int                IDX_W     = stageIdxWidth(NUM_STAGES);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_STAGES - 1);

    rstseqState_t          r_state;
    rstseqState_t          w_stateNext;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cntNext;
    logic [IDX_W-1:0]      r_idx;
    logic [IDX_W-1:0]      w_idxNext;
    logic [NUM_REQ-1:0]    r_grant;
    logic [NUM_REQ-1:0]    w_grantNext;
    logic                  r_busy;
    logic                  w_busyNext;
    logic                  r_done;
    logic                  w_doneNext;
    logic [NUM_STAGES-1:0] r_stageAssert;
    logic [NUM_STAGES-1:0] w_stageNext;

    logic [NUM_REQ-1:0]    w_candidates;
    logic [NUM_REQ-1:0]    w_winner;

`ifdef RSTSEQ_PENDING_EN
    logic [NUM_REQ-1:0]    r_pending;
    logic [NUM_REQ-1:0]    w_pendingNext;

    assign w_candidates = bus.req | r_pending;

    // Outside IDLE every request is remembered; in IDLE only the losers are.
    always_comb begin
        w_pendingNext = r_pending;
        if (r_state == ST_IDLE) begin
            w_pendingNext = w_candidates & ~w_winner;
        end else begin
            w_pendingNext = r_pending | bus.req;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pendingNext;
        end
    end
`else
    assign w_candidates = bus.req;
`endif

    rstseq_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arbiter (
        .i_req   (w_candidates),
        .o_grant (w_winner)
    );

    // Stage vector stays a thermometer code: shifting in ones sets the next
    // higher stage, shifting right clears the highest one still set.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_idxNext   = r_idx;
        w_grantNext = '0;
        w_busyNext  = r_busy;
        w_doneNext  = 1'b0;
        w_stageNext = r_stageAssert;

        unique case (r_state)
            ST_IDLE: begin
                w_busyNext  = 1'b0;
                w_stageNext = '0;
                if (|w_candidates) begin
                    w_grantNext = w_winner;
                    w_busyNext  = 1'b1;
                    w_stageNext = NUM_STAGES'(1);
                    w_idxNext   = '0;
                    if (NUM_STAGES == 1) begin
                        w_stateNext = ST_HOLD;
                        w_cntNext   = HOLD_LOAD;
                    end else begin
                        w_stateNext = ST_ASSERTING;
                        w_cntNext   = GAP_LOAD;
                    end
                end
            end

            ST_ASSERTING: begin
                if (r_cnt == '0) begin
                    w_idxNext   = r_idx + 1'b1;
                    w_stageNext = (r_stageAssert << 1) | NUM_STAGES'(1);
                    if (w_idxNext == LAST_IDX) begin
                        w_stateNext = ST_HOLD;
                        w_cntNext   = HOLD_LOAD;
                    end else begin
                        w_cntNext   = GAP_LOAD;
                    end
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end

            ST_HOLD: begin
                if (r_cnt == '0) begin
                    w_stageNext = r_stageAssert >> 1;
                    w_stateNext = ST_RELEASING;
                    w_cntNext   = GAP_LOAD;
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end

            // One idle cycle after stage 0 drops before DONE is raised.
            ST_RELEASING: begin
                if (!r_stageAssert[0]) begin
                    w_stateNext = ST_FINISH;
                    w_doneNext  = 1'b1;
                    w_cntNext   = '0;
                end else if (r_cnt == '0) begin
                    w_idxNext   = r_idx - 1'b1;
                    w_stageNext = r_stageAssert >> 1;
                    w_cntNext   = GAP_LOAD;
                end else begin
                    w_cntNext = r_cnt - 1'b1;
                end
            end

            ST_FINISH: begin
                w_stateNext = ST_IDLE;
                w_busyNext  = 1'b0;
            end

            default: begin
                w_stateNext = ST_IDLE;
                w_busyNext  = 1'b0;
                w_stageNext = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_grant       <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_stageAssert <= '0;
        end else begin
            r_state       <= w_stateNext;
            r_cnt         <= w_cntNext;
            r_idx         <= w_idxNext;
            r_grant       <= w_grantNext;
            r_busy        <= w_busyNext;
            r_done        <= w_doneNext;
            r_stageAssert <= w_stageNext;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.stageAssert = r_stageAssert;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default build plus a 1-stage/1-gap/
// 1-hold instance; expectations follow RSTSEQ_PENDING_EN when it is defined.
module tb_reset_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NUM_REQ(2), .NUM_STAGES(3)) busMain ();
    reset_sequencer_if #(.NUM_REQ(2), .NUM_STAGES(1)) busShort ();

    reset_sequencer #(
        .NUM_STAGES  (3),
        .NUM_REQ     (2),
        .GAP_CYCLES  (4),
        .HOLD_CYCLES (16),
        .CNT_W       (8)
    ) dutMain (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busMain)
    );

    reset_sequencer #(
        .NUM_STAGES  (1),
        .NUM_REQ     (2),
        .GAP_CYCLES  (1),
        .HOLD_CYCLES (1),
        .CNT_W       (8)
    ) dutShort (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busShort)
    );

    logic [3:0] refReq;
    logic [3:0] refGrant;

    rstseq_arbiter #(.NUM_REQ(4)) refArb (
        .i_req   (refReq),
        .o_grant (refGrant)
    );

    // Invariants on the main instance, sampled mid-cycle.
    logic [2:0] prevStage = 3'b000;
    bit         seqGranted = 1'b0;

    always @(negedge clk) begin
        if (rst) begin
            prevStage  = 3'b000;
            seqGranted = 1'b0;
        end else begin
            total++;
            if (((busMain.stageAssert & (busMain.stageAssert + 3'd1)) !== 3'b000) ||
                ($countones(busMain.stageAssert ^ prevStage) > 1)) begin
                bad++;
                $display("[TB] FAIL stage_order got=%b prev=%b", busMain.stageAssert, prevStage);
            end
            prevStage = busMain.stageAssert;
            total++;
            if (!$onehot0(busMain.grant) || (seqGranted && (busMain.grant !== 2'b00))) begin
                bad++;
                $display("[TB] FAIL grant_onehot got=%b already=%0d", busMain.grant, seqGranted);
            end
            if (busMain.grant !== 2'b00) seqGranted = 1'b1;
            if (busMain.busy === 1'b0) seqGranted = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] expStage(input int n);
        if (n >= 1 && n <= 4)   return 3'b001;
        if (n >= 5 && n <= 8)   return 3'b011;
        if (n >= 9 && n <= 24)  return 3'b111;
        if (n >= 25 && n <= 28) return 3'b011;
        if (n >= 29 && n <= 32) return 3'b001;
        return 3'b000;
    endfunction

    task automatic waitIdle(input int maxCycles);
        for (int i = 0; i < maxCycles && busMain.busy !== 1'b0; i++) tick();
        total++;
        if (busMain.busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL wait_idle busy=%b required=0", busMain.busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        busMain.req  = 2'b00;
        busShort.req = 2'b00;
        repeat (3) tick();
        total++;
        if ({busMain.grant, busMain.busy, busMain.done, busMain.stageAssert} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_main got=%b required=0",
                     {busMain.grant, busMain.busy, busMain.done, busMain.stageAssert});
        end
        total++;
        if ({busShort.grant, busShort.busy, busShort.done, busShort.stageAssert} !== 5'b0) begin
            bad++;
            $display("[TB] FAIL reset_short got=%b required=0",
                     {busShort.grant, busShort.busy, busShort.done, busShort.stageAssert});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_sequence();
        logic [6:0] got, want;
        busMain.req = 2'b01;
        tick();
        busMain.req = 2'b00;
        for (int n = 1; n <= 36; n++) begin
            if (n > 1) tick();
            want = {((n == 1) ? 2'b01 : 2'b00), (n >= 1 && n <= 34), (n == 34), expStage(n)};
            got  = {busMain.grant, busMain.busy, busMain.done, busMain.stageAssert};
            total++;
            if (got !== want) begin
                bad++;
                $display("[TB] FAIL single t+%0d got=%b required=%b", n, got, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        busMain.req = 2'b11;
        tick();
        busMain.req = 2'b10;
        total++;
        if ({busMain.grant, busMain.stageAssert} !== 5'b01_001) begin
            bad++;
            $display("[TB] FAIL b2b_first got=%b required=01001", {busMain.grant, busMain.stageAssert});
        end
        for (int n = 2; n <= 35; n++) begin
            tick();
            total++;
            if (busMain.grant !== 2'b00 || busMain.done !== (n == 34)) begin
                bad++;
                $display("[TB] FAIL b2b_gap t+%0d grant=%b done=%b", n, busMain.grant, busMain.done);
            end
        end
        tick();
        busMain.req = 2'b00;
        total++;
        if ({busMain.grant, busMain.busy, busMain.stageAssert} !== 6'b10_1_001) begin
            bad++;
            $display("[TB] FAIL b2b_second got=%b required=101001",
                     {busMain.grant, busMain.busy, busMain.stageAssert});
        end
        waitIdle(40);
        tick();
    endtask

    task automatic test_pending();
        logic [1:0] wantGrant;
`ifdef RSTSEQ_PENDING_EN
        wantGrant = 2'b10;
`else
        wantGrant = 2'b00;
`endif
        busMain.req = 2'b01;
        tick();
        busMain.req = 2'b00;
        for (int n = 2; n <= 36; n++) begin
            tick();
            if (n == 10) busMain.req = 2'b10;
            if (n == 11) busMain.req = 2'b00;
            if (n == 34) begin
                total++;
                if (busMain.done !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL pend_done got=%b required=1", busMain.done);
                end
            end
        end
        total++;
        if (busMain.grant !== wantGrant) begin
            bad++;
            $display("[TB] FAIL pend_grant got=%b required=%b", busMain.grant, wantGrant);
        end
        waitIdle(40);
        tick();
    endtask

    task automatic test_reset_mid();
        busMain.req = 2'b01;
        tick();
        busMain.req = 2'b00;
        for (int n = 2; n <= 20; n++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({busMain.grant, busMain.busy, busMain.done, busMain.stageAssert} !== 7'b0) begin
            bad++;
            $display("[TB] FAIL abort_clear got=%b required=0",
                     {busMain.grant, busMain.busy, busMain.done, busMain.stageAssert});
        end
        for (int n = 22; n <= 40; n++) begin
            tick();
            total++;
            if (busMain.done !== 1'b0 || busMain.stageAssert !== 3'b000) begin
                bad++;
                $display("[TB] FAIL abort_quiet t+%0d done=%b stage=%b", n, busMain.done, busMain.stageAssert);
            end
        end
        busMain.req = 2'b01;
        tick();
        busMain.req = 2'b00;
        total++;
        if ({busMain.grant, busMain.busy, busMain.stageAssert} !== 6'b01_1_001) begin
            bad++;
            $display("[TB] FAIL abort_regrant got=%b required=011001",
                     {busMain.grant, busMain.busy, busMain.stageAssert});
        end
        waitIdle(40);
        tick();
    endtask

    task automatic test_short_config();
        logic [4:0] want [1:4];
        logic [4:0] got;
        want[1] = 5'b01_1_0_1;
        want[2] = 5'b00_1_0_0;
        want[3] = 5'b00_1_1_0;
        want[4] = 5'b00_0_0_0;
        busShort.req = 2'b01;
        tick();
        busShort.req = 2'b00;
        for (int n = 1; n <= 4; n++) begin
            if (n > 1) tick();
            got = {busShort.grant, busShort.busy, busShort.done, busShort.stageAssert};
            total++;
            if (got !== want[n]) begin
                bad++;
                $display("[TB] FAIL short t+%0d got=%b required=%b", n, got, want[n]);
            end
        end
    endtask

    task automatic test_arbiter_ref();
        logic [3:0] vecIn  [5];
        logic [3:0] vecOut [5];
        vecIn  = '{4'b0000, 4'b0110, 4'b1000, 4'b1011, 4'b1111};
        vecOut = '{4'b0000, 4'b0010, 4'b1000, 4'b0001, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            refReq = vecIn[i];
            #1;
            total++;
            if (refGrant !== vecOut[i]) begin
                bad++;
                $display("[TB] FAIL arbiter in=%b got=%b required=%b", vecIn[i], refGrant, vecOut[i]);
            end
        end
    endtask

    initial begin
        refReq = 4'b0000;
        test_reset();
        test_single_sequence();
        test_back_to_back();
        test_pending();
        test_reset_mid();
        test_short_config();
        test_arbiter_ref();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
